wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
Two-master Wishbone (classic) arbiter that shares the single-port wb_ram slave between the management SoC bus (master 0) and the simple CPU's load/store port (master 1). It grants whole bus cycles (held while the granted master's cyc stays high) using round-robin priority. It routes the slave's ack and data back only to the granted master. It sits between the two bus masters and the wb_ram Wishbone port; the RAM's side read port is not touched.

Parameters:
ADDR_W, 32, address width of all Wishbone address ports
DATA_W, 32, data width of all Wishbone data ports
TIMEOUT, 15, watchdog limit in clocks (used only with WB_ARB_TIMEOUT_EN); counter width = $clog2(TIMEOUT+1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_m0_adr / i_m0_dat / i_m0_sel / i_m0_we / i_m0_cyc / i_m0_stb  in  ADDR_W/DATA_W/DATA_W/8/1/1/1  master 0 (SoC) request
o_m0_dat / o_m0_ack / o_m0_err  out  DATA_W/1/1  master 0 response
i_m1_adr / i_m1_dat / i_m1_sel / i_m1_we / i_m1_cyc / i_m1_stb  in  same as m0  master 1 (CPU) request
o_m1_dat / o_m1_ack / o_m1_err  out  DATA_W/1/1  master 1 response
o_s_adr / o_s_dat / o_s_sel / o_s_we / o_s_cyc / o_s_stb  out  ADDR_W/DATA_W/DATA_W/8/1/1/1  to wb_ram
i_s_dat / i_s_ack  in  DATA_W/1  from wb_ram
o_grant  out  2  one-hot current owner (01=m0, 10=m1, 00=idle)

Behaviour:
- Reset is synchronous on i_clk via i_reset, active-high. Reset state: FSM=IDLE, last_owner=1 (so m0 wins the first tie), o_grant=00, timeout counter=0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE, no master cyc high: stay in IDLE.
- IDLE, exactly one master has cyc high: go to OWNn for that master.
- IDLE, both masters have cyc high: grant the master that is not last_owner.
- On any grant, update last_owner.
- OWNn: stay while i_mn_cyc is high. Return to IDLE on the clock where i_mn_cyc is low.
- There is no direct OWN0->OWN1 transition; IDLE always lasts exactly 1 cycle between owners.
- Arbitration latency: a grant registered at edge k drives the slave in cycle k. With wb_ram's registered ack, a single access is acked 2 clocks after the master raises cyc/stb.
- Slave outputs are a combinational mux from the owning master. In IDLE, o_s_cyc=o_s_stb=0; the other slave outputs are don't-care and are driven from m0.
- o_mn_ack = i_s_ack & (owner==n). o_mn_dat = i_s_dat for both masters; it is valid only with ack.
- The non-owner sees ack=0 and err=0 and is stalled; its request is held pending.
- Owner drops cyc in the same cycle as the slave ack: the ack is still delivered, and the grant is released at the next edge.
- Owner drops cyc before ack: o_s_cyc falls with it, and any later stray ack is discarded because the FSM is IDLE.
- Reset mid-cycle: the grant is dropped immediately (o_s_cyc=0 the next cycle) and no ack is forwarded.
- Masters may hold cyc across several stb strobes; the arbiter never pre-empts an owner.

Optional Feature:
- Macro name: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every grant and on every i_s_ack, and increments each OWNn cycle that has stb high and no ack.
  - When the counter reaches TIMEOUT, o_mn_err is pulsed for 1 cycle to the owner, o_s_cyc/o_s_stb are forced low that cycle, and the FSM returns to IDLE.
- Without the macro: no counter exists, o_m0_err and o_m1_err are tied 0, and a stalled slave holds the bus indefinitely.

Decomposition:
- Package wb_arb_pkg holds the owner-state localparams (IDLE/OWN0/OWN1 encoding) and the default width constants.
- Sub-module wb_arb_rr2: 2-requester round-robin picker (inputs req[1:0], last_owner; output pick). It is combinational and reusable if a third master is added.
- The FSM, the mux and the timeout logic stay in the top module.

Test Plan:
- m0 alone writes 0xDEADBEEF, sel=4'hF, to adr 0x08, then reads adr 0x08 -> each access acked 2 clks after stb; read o_m0_dat=0xDEADBEEF; o_m1_ack stays 0.
- m0 and m1 raise cyc in the same clock after reset -> o_grant=01 first. m0 drops cyc after its ack -> 1 idle cycle, then o_grant=10 and m1 is acked.
- m1 holds cyc for 3 back-to-back reads while m0 requests -> m0 gets no ack until m1 drops cyc, then m0 is served.
- Alternating contention over 4 rounds with both masters continuously requesting single accesses -> grant sequence m0, m1, m0, m1.
- Reset asserted while OWN1 has stb pending -> the next cycle o_s_cyc=0 and o_grant=00, no ack reaches m1, and the first tie after reset goes to m0.
- WB_ARB_TIMEOUT_EN with a slave that never acks, TIMEOUT=15 -> o_m0_err pulses 15 clks after stb, o_grant returns to 00, and a pending m1 request is granted next.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone RAM arbiter: owner-state encoding and default widths.
package wb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_OWN0 = 2'd1;
  localparam state_t ST_OWN1 = 2'd2;

  localparam int WB_ADDR_W  = 32;
  localparam int WB_DATA_W  = 32;
  localparam int WB_TIMEOUT = 15;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-requester round-robin picker, purely combinational; pick is the winning index and is only meaningful when req != 0.
module wb_arb_rr2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       pick
);

  // On a tie the requester that did not own the bus last time wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last_owner;
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin two-master Wishbone classic arbiter in front of wb_ram; grant takes effect the cycle after cyc, non-owner is stalled.
// Optional watchdog under WB_ARB_TIMEOUT_EN aborts a slave that never acks with a one-cycle err to the owner.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_m0_adr,
  input  logic [DATA_W-1:0]   i_m0_dat,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  input  logic                i_m0_we,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  output logic [DATA_W-1:0]   o_m0_dat,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  input  logic [ADDR_W-1:0]   i_m1_adr,
  input  logic [DATA_W-1:0]   i_m1_dat,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  input  logic                i_m1_we,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  output logic [DATA_W-1:0]   o_m1_dat,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [ADDR_W-1:0]   o_s_adr,
  output logic [DATA_W-1:0]   o_s_dat,
  output logic [DATA_W/8-1:0] o_s_sel,
  output logic                o_s_we,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  input  logic [DATA_W-1:0]   i_s_dat,
  input  logic                i_s_ack,
  output logic [1:0]          o_grant
);

  state_t     state_q, state_d;
  logic       last_q;
  logic [1:0] req;
  logic       pick;
  logic       own0, own1;
  logic       grant_now;
  logic       owner_stb;
  logic       tmo_hit;

  assign req       = {i_m1_cyc, i_m0_cyc};
  assign own0      = (state_q == ST_OWN0);
  assign own1      = (state_q == ST_OWN1);
  assign grant_now = (state_q == ST_IDLE) && (req != 2'b00);
  assign owner_stb = (own0 & i_m0_stb) | (own1 & i_m1_stb);

  wb_arb_rr2 u_rr2 (
    .req        (req),
    .last_owner (last_q),
    .pick       (pick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant_now) last_q <= pick;
    end
  end

  // Owners always pass through IDLE, so a hand-over costs exactly one dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req != 2'b00) state_d = pick ? ST_OWN1 : ST_OWN0;
      ST_OWN0: if (!i_m0_cyc || tmo_hit) state_d = ST_IDLE;
      ST_OWN1: if (!i_m1_cyc || tmo_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_s_adr = i_m0_adr;
    o_s_dat = i_m0_dat;
    o_s_sel = i_m0_sel;
    o_s_we  = i_m0_we;
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    if (own1) begin
      o_s_adr = i_m1_adr;
      o_s_dat = i_m1_dat;
      o_s_sel = i_m1_sel;
      o_s_we  = i_m1_we;
      o_s_cyc = i_m1_cyc;
      o_s_stb = i_m1_stb;
    end else if (own0) begin
      o_s_cyc = i_m0_cyc;
      o_s_stb = i_m0_stb;
    end
    if (tmo_hit) begin
      o_s_cyc = 1'b0;
      o_s_stb = 1'b0;
    end
  end

  // A reset cycle never forwards an ack, even while the old owner is still registered.
  assign o_m0_ack = i_s_ack & own0 & ~i_reset;
  assign o_m1_ack = i_s_ack & own1 & ~i_reset;
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;
  assign o_grant  = {own1, own0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Fires on the TIMEOUT-th unacked strobe cycle, counting the current one.
  assign tmo_hit = owner_stb & ~i_s_ack & (tmo_cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || grant_now || i_s_ack || tmo_hit) tmo_cnt_q <= '0;
    else if (owner_stb)                             tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign o_m0_err = tmo_hit & own0;
  assign o_m1_err = tmo_hit & own1;
`else
  assign tmo_hit  = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed contention cases plus randomized traffic against an ownership model and a memory scoreboard.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic        stall = 1'b0;
  logic        mon_en = 1'b0;

  logic [1:0]  m_cyc = 2'b00;
  logic [1:0]  m_stb = 2'b00;
  logic [1:0]  m_we  = 2'b00;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];

  logic [31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
  logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
  logic [3:0]  o_s_sel;
  logic        o_s_we, o_s_cyc, o_s_stb;
  logic [1:0]  o_grant;
  logic [31:0] s_dat = 32'h0;
  logic        s_ack = 1'b0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  int n_checks = 0;
  int n_err    = 0;
  int own_m    = -1;
  int last_m   = 1;
  int order [$];
  int lat0, lat1, lat2;
  logic [31:0] rd0, rd1;
  bit e0, e1;

  always #5 clk = ~clk;

  wb_ram_arbiter dut (
    .i_clk    (clk),      .i_reset  (rst),
    .i_m0_adr (m_adr[0]), .i_m0_dat (m_dat[0]), .i_m0_sel (m_sel[0]),
    .i_m0_we  (m_we[0]),  .i_m0_cyc (m_cyc[0]), .i_m0_stb (m_stb[0]),
    .o_m0_dat (o_m0_dat), .o_m0_ack (o_m0_ack), .o_m0_err (o_m0_err),
    .i_m1_adr (m_adr[1]), .i_m1_dat (m_dat[1]), .i_m1_sel (m_sel[1]),
    .i_m1_we  (m_we[1]),  .i_m1_cyc (m_cyc[1]), .i_m1_stb (m_stb[1]),
    .o_m1_dat (o_m1_dat), .o_m1_ack (o_m1_ack), .o_m1_err (o_m1_err),
    .o_s_adr  (o_s_adr),  .o_s_dat  (o_s_dat),  .o_s_sel  (o_s_sel),
    .o_s_we   (o_s_we),   .o_s_cyc  (o_s_cyc),  .o_s_stb  (o_s_stb),
    .i_s_dat  (s_dat),    .i_s_ack  (s_ack),
    .o_grant  (o_grant)
  );

  // wb_ram stand-in: registered single-cycle ack; ignores i_reset so stray acks can reach the arbiter.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      s_ack <= 1'b0;
    end else if (o_s_cyc && o_s_stb && !s_ack && !stall) begin
      s_ack <= 1'b1;
      s_dat <= mem[o_s_adr[5:2]];
      if (o_s_we)
        for (int b = 0; b < 4; b++)
          if (o_s_sel[b]) mem[o_s_adr[5:2]][b*8 +: 8] <= o_s_dat[b*8 +: 8];
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ownership model: who should own the bus, derived from the arbitration rules.
  always @(posedge clk) begin
    if (rst) begin
      own_m  <= -1;
      last_m <= 1;
    end else if (own_m >= 0) begin
      if (!m_cyc[own_m[0]]) own_m <= -1;
    end else if (m_cyc == 2'b11) begin
      own_m  <= 1 - last_m;
      last_m <= 1 - last_m;
    end else if (m_cyc != 2'b00) begin
      own_m  <= m_cyc[1] ? 1 : 0;
      last_m <= m_cyc[1] ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("grant", o_grant, (own_m == 0) ? 2'b01 : (own_m == 1) ? 2'b10 : 2'b00);
      check("ack", {o_m1_ack, o_m0_ack},
            {s_ack && own_m == 1 && !rst, s_ack && own_m == 0 && !rst});
      check("err", {o_m1_err, o_m0_err}, 2'b00);
      check("rsp_dat", {o_m1_dat, o_m0_dat}, {s_dat, s_dat});
      if (own_m < 0) begin
        check("s_cyc_idle", {o_s_cyc, o_s_stb}, 2'b00);
      end else begin
        check("s_cyc", {o_s_cyc, o_s_stb}, {m_cyc[own_m[0]], m_stb[own_m[0]]});
        check("s_req", {o_s_adr, o_s_dat}, {m_adr[own_m[0]], m_dat[own_m[0]]});
        check("s_ctl", {o_s_sel, o_s_we}, {m_sel[own_m[0]], m_we[own_m[0]]});
      end
    end
  end

  // One Wishbone classic access; lat counts clocks from raising stb to ack/err.
  task automatic access(input int m, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit hold,
                        output int lat, output logic [31:0] rdat, output bit err);
    bit done;
    @(posedge clk); #1;
    m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_we[m] = we;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    lat = 0; done = 0; err = 0; rdat = 32'h0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if ((m == 0) ? (o_m0_ack | o_m0_err) : (o_m1_ack | o_m1_err)) done = 1;
    end
    if (!done) check("access_wait", 1'b0, 1'b1);
    err  = (m == 0) ? o_m0_err : o_m1_err;
    rdat = (m == 0) ? o_m0_dat : o_m1_dat;
    if (done && !err) begin
      order.push_back(m);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[adr[5:2]][b*8 +: 8] = dat[b*8 +: 8];
      end else begin
        check("rd_data", rdat, ref_mem[adr[5:2]]);
      end
    end
    m_stb[m] = 1'b0;
    if (!hold || err) m_cyc[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    bit hold, e;
    int l;
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      hold = (i < n - 1) && ($urandom_range(0, 3) == 0);
      access(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), hold, l, r, e);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 2; i++) begin m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", o_grant, 2'b00);
    check("rst_s_cyc", {o_s_cyc, o_s_stb}, 2'b00);
    check("rst_ack", {o_m1_ack, o_m0_ack, o_m1_err, o_m0_err}, 4'b0000);
    rst = 1'b0; mem_clr = 1'b0; mon_en = 1'b1;

    // m0 alone: write then read back
    access(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 0, lat0, rd0, e0);
    check("m0_wr_lat", lat0, 2);
    access(0, 0, 32'h08, 32'h0, 4'hF, 0, lat0, rd0, e0);
    check("m0_rd_lat", lat0, 2);
    check("m0_rd_dat", rd0, 32'hDEADBEEF);

    // first tie after reset goes to m0, m1 follows after one idle cycle
    do_reset();
    fork
      access(0, 1, 32'h10, 32'h11112222, 4'hF, 0, lat0, rd0, e0);
      access(1, 1, 32'h14, 32'h33334444, 4'h3, 0, lat1, rd1, e1);
    join
    check("tie_m0_lat", lat0, 2);
    check("tie_m1_lat", lat1, 5);

    // m1 holds cyc over three reads; m0 waits for release
    fork
      begin
        access(1, 0, 32'h08, 32'h0, 4'hF, 1, lat1, rd1, e1);
        check("hold_lat_a", lat1, 2);
        access(1, 0, 32'h10, 32'h0, 4'hF, 1, lat1, rd1, e1);
        check("hold_lat_b", lat1, 1);
        access(1, 0, 32'h14, 32'h0, 4'hF, 0, lat1, rd1, e1);
        check("hold_lat_c", lat1, 1);
      end
      begin
        @(posedge clk);
        access(0, 0, 32'h14, 32'h0, 4'hF, 0, lat0, rd0, e0);
        check("wait_m0_lat", lat0, 8);
      end
    join

    // four rounds of continuous contention alternate strictly
    do_reset();
    order.delete();
    fork
      for (int i = 0; i < 4; i++) access(0, 1, 32'h20 + 32'(i*8), $urandom, 4'hF, 0, lat0, rd0, e0);
      for (int i = 0; i < 4; i++) access(1, 1, 32'h24 + 32'(i*8), $urandom, 4'hF, 0, lat1, rd1, e1);
    join
    check("rr_count", order.size(), 8);
    for (int i = 0; i < order.size(); i++) check($sformatf("rr_order%0d", i), order[i], i % 2);

    // reset while m1 owns the bus with a strobe pending
    @(posedge clk); #1;
    m_adr[1] = 32'h08; m_we[1] = 1'b0; m_sel[1] = 4'hF;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_grant", o_grant, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_s_cyc", o_s_cyc, 1'b0);
    check("midrst_grant", o_grant, 2'b00);
    check("midrst_ack", {o_m1_ack, o_m0_ack}, 2'b00);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      access(0, 0, 32'h08, 32'h0, 4'hF, 0, lat0, rd0, e0);
      access(1, 0, 32'h10, 32'h0, 4'hF, 0, lat1, rd1, e1);
    join
    check("postrst_m0_lat", lat0, 2);
    check("postrst_m1_lat", lat1, 5);

    // randomized traffic from both masters
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: watchdog aborts m0, pending m1 is served next
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    stall = 1'b1;
    fork
      begin
        access(0, 0, 32'h08, 32'h0, 4'hF, 0, lat0, rd0, e0);
        check("tmo_lat", lat0, 15);
        check("tmo_err", e0, 1'b1);
        @(posedge clk); #1;
        check("tmo_grant_idle", o_grant, 2'b00);
        stall = 1'b0;
      end
      begin
        @(posedge clk);
        access(1, 0, 32'h08, 32'h0, 4'hF, 0, lat2, rd1, e1);
        check("tmo_m1_lat", lat2, 17);
        check("tmo_m1_err", e1, 1'b0);
      end
    join
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
